// File: rtl/pwm_pkg.sv
// Shared register map, control bits and types for the MMIO PWM LED block.
package pwm_pkg;

  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_PRESCALE = 1;
  localparam int ADDR_DUTY0    = 2;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_INVERT = 1;

  localparam int PSC_W = 16;

  typedef struct packed {
    logic invert;
    logic enable;
  } ctrl_t;

endpackage

// File: rtl/mmio_pwm_leds_channel.sv
// One PWM channel: active duty register, compare and output flop.
// Build with PWM_FADE_EN to step the active duty one LSB per period.
module pwm_channel #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PWM_W:0]   shadow,
  input  logic [PWM_W-1:0] cnt,
  input  logic             wrap,
  input  logic             enable,
  input  logic             invert,
  output logic             pwm_out
);

  logic [PWM_W:0] active;
  logic [PWM_W:0] next_wrap;
  logic           raw;

`ifdef PWM_FADE_EN
  localparam logic [PWM_W:0] ONE = 1;

  always_comb begin
    next_wrap = active;
    if (active < shadow)
      next_wrap = active + ONE;
    else if (active > shadow)
      next_wrap = active - ONE;
  end
`else
  always_comb begin
    next_wrap = shadow;
  end
`endif

  // Widened compare: duty >= 2^PWM_W is full-on.
  assign raw = enable && ({1'b0, cnt} < active);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (!enable)
        active <= shadow;
      else if (wrap)
        active <= next_wrap;
      pwm_out <= raw ^ invert;
    end
  end

endmodule

// File: rtl/mmio_pwm_leds.sv
// Memory-mapped NCH-channel PWM LED driver on the data-memory bus.
// Optional PWM_FADE_EN gives per-period duty fading in each channel.
module mmio_pwm_leds
  import pwm_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int PWM_W        = 8,
  parameter int ADDR_W       = 5,
  parameter int PRESCALE_RST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic [NCH-1:0]    pwm_out,
  output logic              period_tick
);

  localparam logic [PWM_W-1:0] CNT_MAX = '1;
  localparam logic [PWM_W-1:0] CNT_ONE = 1;
  localparam logic [PSC_W-1:0] PSC_ONE = 1;

  ctrl_t            ctrl;
  logic [PSC_W-1:0] prescale;
  logic [PSC_W-1:0] psc;
  logic [PWM_W-1:0] cnt;
  logic [PWM_W:0]   shadow [NCH];
  logic             tick;
  logic             wrap;
  logic             wr;
  logic             rd;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr           = sel && we;
  assign rd           = sel && !we;
  assign tick         = ctrl.enable && (psc >= prescale);
  assign wrap         = tick && (cnt == CNT_MAX);
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= '0;
      prescale <= PSC_W'(PRESCALE_RST);
      for (int k = 0; k < NCH; k++)
        shadow[k] <= '0;
    end else if (wr) begin
      if (addr == ADDR_W'(ADDR_CTRL))
        ctrl <= ctrl_t'(wdata[1:0]);
      if (addr == ADDR_W'(ADDR_PRESCALE))
        prescale <= wdata[PSC_W-1:0];
      for (int k = 0; k < NCH; k++)
        if (addr == ADDR_W'(ADDR_DUTY0 + k))
          shadow[k] <= wdata[PWM_W:0];
    end
  end

  // Disabled: hold the timebase at zero so re-enable starts a clean period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc         <= '0;
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
      if (!ctrl.enable) begin
        psc <= '0;
        cnt <= '0;
      end else if (tick) begin
        psc <= '0;
        cnt <= cnt + CNT_ONE;
      end else begin
        psc <= psc + PSC_ONE;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (addr == ADDR_W'(ADDR_CTRL))
      rd_mux[1:0] = ctrl;
    if (addr == ADDR_W'(ADDR_PRESCALE))
      rd_mux[PSC_W-1:0] = prescale;
    for (int k = 0; k < NCH; k++)
      if (addr == ADDR_W'(ADDR_DUTY0 + k))
        rd_mux[PWM_W:0] = shadow[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd;
      if (rd)
        rdata <= rd_mux;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pwm_channel #(
      .PWM_W (PWM_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .shadow  (shadow[k]),
      .cnt     (cnt),
      .wrap    (wrap),
      .enable  (ctrl.enable),
      .invert  (ctrl.invert),
      .pwm_out (pwm_out[k])
    );
  end

endmodule

// File: doc/mmio_pwm_leds.md
Name: mmio_pwm_leds

Overview:
- Memory-mapped, parametrised PWM output block for the multicycle RISC-V core.
- Replaces the fixed on/off LED and RGB bits driven from the datapath with NCH independently dimmable channels.
- Sits on the datapath's data-memory bus beside RAM and decodes its own word-address window.
- Drives board LEDs, either directly or through the INVERT control bit for active-low pins.

Parameters:
NCH, 4, number of PWM channels (1..16)
PWM_W, 8, PWM counter width; period = 2^PWM_W prescaled ticks
ADDR_W, 5, word-address width of the register window; 2+NCH <= 2^ADDR_W
PRESCALE_RST, 0, reset value of the PRESCALE register

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sel  in  1  bus select for this block's window
we  in  1  write strobe (qualified by sel)
addr  in  ADDR_W  word address within window
wdata  in  32  write data
rdata  out  32  read data, valid when rvalid
rvalid  out  1  one-cycle read-response pulse
pwm_out  out  NCH  registered PWM outputs
period_tick  out  1  one-cycle pulse at each PWM period wrap

Behaviour:
- Reset and clocking: clock is clk; reset is asynchronous and active-high. Reset values: CTRL=0, PRESCALE=PRESCALE_RST, all DUTY shadow/active=0, counters=0, pwm_out=0, rdata=0, rvalid=0, period_tick=0.
- Register map (word addresses):
  - 0 CTRL: bit0 ENABLE, bit1 INVERT; other bits read 0.
  - 1 PRESCALE: bits [15:0].
  - 2+k DUTY[k]: bits [PWM_W:0], k=0..NCH-1.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Writes: take effect at the clock edge where sel&&we.
- Reads: sel&&!we captures rdata at the edge; rvalid=1 for exactly the following cycle. rdata holds its value until the next read.
- Prescaler:
  - psc counts 0..PRESCALE; tick when psc>=PRESCALE, then psc<=0.
  - If PRESCALE is lowered below psc, the ">=" compare ticks on the next cycle.
  - PRESCALE=0 gives a tick every cycle.
- PWM counter:
  - cnt increments on tick and wraps from 2^PWM_W-1 to 0.
  - wrap = tick && cnt==max; period_tick = wrap, registered (1-cycle delay).
- Duty update:
  - Writes go to shadow. At wrap, active <= shadow.
  - Write coincident with wrap: active takes the pre-write shadow value; the new value applies from the following period.
- Output:
  - raw[k] = ENABLE && (cnt < active[k]); pwm_out[k] <= raw[k] ^ INVERT.
  - Duty 0: constant low. Duty >= 2^PWM_W: constant high (saturate; values above 2^PWM_W are stored but compare as full-on).
- Disable (ENABLE=0):
  - psc and cnt held at 0; no ticks and no period_tick.
  - active <= shadow every cycle.
  - pwm_out = INVERT, so idle-high with INVERT=1.
- Re-enable: counting starts the cycle after the write, from cnt=0.
- Reset mid-period: everything returns immediately to reset values. No partial pulse after reset deassertion.

Optional Feature:
- Macro: PWM_FADE_EN.
- Defined: at each wrap, active[k] moves one LSB toward shadow[k] (incr/decr/hold) instead of jumping, giving hardware fades. ENABLE=0 still loads active directly.
- Undefined: active loads shadow directly at wrap; no stepper logic is present.

Decomposition:
- Package pwm_pkg:
  - register address localparams (ADDR_CTRL=0, ADDR_PRESCALE=1, ADDR_DUTY0=2);
  - CTRL bit indices;
  - PRESCALE width (16);
  - typedef for the ctrl struct.
- Sub-module pwm_channel, instantiated NCH times: holds the active duty register, the optional fade stepper, and the comparator + output flop. Inputs are shadow, cnt, wrap, enable, invert.

Test Plan:
- Reset: assert reset mid-operation with DUTY0=128 running -> pwm_out=0, rvalid=0, PRESCALE reads PRESCALE_RST after release.
- Duty ratio: PRESCALE=0, DUTY0=64, ENABLE=1, PWM_W=8 -> pwm_out[0] high exactly 64 of every 256 cycles; period_tick every 256 cycles.
- Boundaries: DUTY1=0 -> pwm_out[1] always 0; DUTY2=256 and DUTY3=300 -> always 1; INVERT=1 flips all, and ENABLE=0 gives pwm_out=4'b1111.
- Shadow timing: write DUTY0=200 mid-period, and again on the wrap cycle -> old duty persists to period end; the wrap-cycle write appears one period later.
- Prescaler: PRESCALE=3 -> period 1024 cycles; lowering PRESCALE from 9 to 2 while psc=7 -> tick the next cycle.
- Bus and fade: read addr 2 -> rvalid exactly 1 cycle later with the written value; unmapped addr 31 reads 0. With PWM_FADE_EN, shadow 0->5 -> active reaches 5 after 5 wraps.
